data_mem_pipe: RTL and testbench
================================

DATA_MEM_PIPE -- requirements
Module: data_mem_pipe

Interface
REQ-001 Parameter XLEN, default 32: data and address width in bits.
REQ-002 Parameter DEPTH, default 64: memory depth in XLEN-bit words; power of two, 4..4096.
REQ-003 Parameter LAT, default 1: cycles from request acceptance to rsp_valid; legal range 1..4.
REQ-004 Port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 Port rst  input  1: asynchronous, active-low reset.
REQ-006 Port req_valid  input  1: request present this cycle.
REQ-007 Port req_ready  output  1: block accepts a request this cycle.
REQ-008 Port req_we  input  1: 1 = store, 0 = load.
REQ-009 Port req_funct3  input  3: RV32I size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 Port req_addr  input  XLEN: byte address.
REQ-011 Port req_wdata  input  XLEN: store data; the low bytes are used per size.
REQ-012 Port rsp_valid  output  1: response strobe, one cycle per accepted request.
REQ-013 Port rsp_data  output  XLEN: load result, already extended.
REQ-014 Port rsp_err  output  1: the accepted request was illegal and had no effect.

Function
REQ-015 The FSM SHALL have two states, INIT and RUN; INIT is entered on reset.
REQ-016 In INIT, req_ready = 0 and one word per cycle SHALL be written to zero, index 0..DEPTH-1; the state becomes RUN after the word DEPTH-1 is cleared.
REQ-017 In INIT the block SHALL take exactly DEPTH cycles after rst deasserts; requests are ignored.
REQ-018 In RUN, req_ready = 1; a request is accepted on any edge where req_valid && req_ready.
REQ-019 Word index = req_addr[log2(DEPTH)+1:2]; lane = req_addr[1:0].
REQ-020 Illegal conditions:
- H or HU with lane[0] != 0.
- W with lane != 0.
- req_addr >= 4*DEPTH.
- funct3 of 011, 110 or 111.
- A store with funct3 100 or 101.
REQ-021 An illegal request SHALL cause no memory write and SHALL return rsp_err = 1, rsp_data = 0.
REQ-022 A legal store SHALL write only the addressed byte lanes at the acceptance edge:
- B: 1 lane, from wdata[7:0].
- H: 2 lanes, from wdata[15:0].
- W: 4 lanes.
- All other bytes of the word are unchanged.
REQ-023 A legal load SHALL read the word at the acceptance edge, select the lane, and extend it:
- B, H: sign-extend.
- BU, HU: zero-extend.
- W: unchanged.
REQ-024 A store SHALL return rsp_valid with rsp_data = 0 and rsp_err = 0.
REQ-025 rsp_valid, rsp_data and rsp_err SHALL appear exactly LAT cycles after acceptance, through a LAT-stage register pipeline.
REQ-026 The pipeline SHALL accept back-to-back requests at one per cycle, with responses in order.
REQ-027 A load accepted the cycle after a store to the same word SHALL return the post-store data.
REQ-028 rsp_data and rsp_err SHALL hold 0 in any cycle where rsp_valid = 0.

Reset
REQ-029 rst low SHALL immediately force: rsp_valid = 0, rsp_data = 0, rsp_err = 0, req_ready = 0, all pipeline stages invalid, FSM = INIT, clear counter = 0.
REQ-030 Reset asserted mid-INIT or mid-RUN SHALL restart the full INIT sequence; in-flight responses are discarded.
REQ-031 Memory contents are defined only by the INIT clear and later stores; the array has no reset term.

Verification
REQ-032 Release rst, count cycles -> req_ready rises after exactly DEPTH=64 cycles; a LW from any address returns 0x00000000.
REQ-033 SW 0x8000_FF7F @0x10, then LB @0x10, LBU @0x10, LH @0x12, LHU @0x12 -> responses are 0x0000007F, 0x0000007F, 0xFFFF8000, 0x00008000.
REQ-034 SW 0x11223344 @0x20, then SB 0xAA @0x21 and SH 0xBEEF @0x22, then LW @0x20 -> 0xBEEFAA44.
REQ-035 LW @0x22, SH @0x03, LW @0x100 (DEPTH=64), funct3=011 -> each gives rsp_err=1 and rsp_data=0; a following LW @0x00 is unchanged.
REQ-036 LAT=3: issue 4 back-to-back loads -> rsp_valid is high on cycles 3..6 after the first acceptance, in request order; SW followed immediately by LW to the same word returns the new data.
REQ-037 Pulse rst low while a response is in flight -> rsp_valid drops at once, no stale response appears, and req_ready stays low for 64 cycles.

Source files
------------

// File: rtl/data_mem_pipe.sv
// -----------------------------------------------------------------------------
// data_mem_pipe
//   Byte-addressable RV32I-style data memory with a fixed-latency response
//   pipeline. After reset the array is cleared one word per cycle (INIT), then
//   loads and stores are accepted one per cycle (RUN). Each accepted request
//   yields exactly one response LAT cycles later, in request order.
//
// Parameters
//   XLEN   data / address width in bits
//   DEPTH  memory depth in XLEN-bit words (power of two, 4..4096)
//   LAT    request-acceptance to rsp_valid latency in cycles (1..4)
//
// Ports
//   clk         clock, all state changes on its rising edge
//   rst         asynchronous active-low reset
//   req_valid   request present
//   req_ready   block accepts a request this cycle (high only in RUN)
//   req_we      1 = store, 0 = load
//   req_funct3  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr    byte address
//   req_wdata   store data, low bytes used per size
//   rsp_valid   one-cycle response strobe per accepted request
//   rsp_data    extended load result (0 for stores, errors and idle cycles)
//   rsp_err     accepted request was illegal and had no effect
// -----------------------------------------------------------------------------
module data_mem_pipe #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 64,
   parameter int LAT   = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            rsp_valid,
   output logic [XLEN-1:0] rsp_data,
   output logic            rsp_err
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {ST_INIT, ST_RUN} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   clr_cnt_q, clr_cnt_d;

   logic            pipe_valid_q [LAT];
   logic            pipe_valid_d [LAT];
   logic [XLEN-1:0] pipe_data_q  [LAT];
   logic [XLEN-1:0] pipe_data_d  [LAT];
   logic            pipe_err_q   [LAT];
   logic            pipe_err_d   [LAT];

   logic [XLEN-1:0] mem_q [DEPTH];

   // Request decode
   logic            accept;
   logic [AW-1:0]   word_idx;
   logic [1:0]      lane;
   logic            addr_oob;
   logic            size_bad;
   logic            illegal;

   // Memory write/read paths
   logic            clr_en;
   logic            st_en;
   logic [3:0]      st_be;
   logic [XLEN-1:0] st_word;
   logic [XLEN-1:0] rd_word;
   logic [7:0]      rd_byte;
   logic [15:0]     rd_half;
   logic [XLEN-1:0] ld_val;

   // --------------------------------------------------------------------------
   // FSM next state: clear counter walks 0..DEPTH-1, then RUN.
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      req_ready = 1'b0;
      clr_en    = 1'b0;
      case (state_q)
         ST_INIT: begin
            clr_en    = 1'b1;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == AW'(DEPTH - 1)) begin
               state_d   = ST_RUN;
               clr_cnt_d = '0;
            end
         end
         ST_RUN: req_ready = 1'b1;
         default: state_d = ST_INIT;
      endcase
   end

   // --------------------------------------------------------------------------
   // Request decode, store lane enables and load extension.
   // --------------------------------------------------------------------------
   always_comb begin
      accept   = req_valid && req_ready;
      word_idx = req_addr[AW+1:2];
      lane     = req_addr[1:0];
      // Any address bit above the word index means the byte address is past
      // the end of the array (DEPTH is a power of two).
      addr_oob = (req_addr >> (AW + 2)) != '0;

      size_bad = 1'b1;
      st_be    = 4'b0000;
      st_word  = req_wdata;
      case (req_funct3)
         F3_B: begin
            size_bad = 1'b0;
            st_be    = 4'b0001 << lane;
            st_word  = {(XLEN/8){req_wdata[7:0]}};
         end
         F3_H: begin
            size_bad = lane[0];
            st_be    = 4'b0011 << lane;
            st_word  = {(XLEN/16){req_wdata[15:0]}};
         end
         F3_W: begin
            size_bad = lane != 2'b00;
            st_be    = 4'b1111;
         end
         // Unsigned sizes exist only for loads.
         F3_BU:   size_bad = req_we;
         F3_HU:   size_bad = req_we | lane[0];
         default: size_bad = 1'b1;
      endcase
      illegal = size_bad | addr_oob;
      st_en   = accept && req_we && !illegal;

      // Combinational read so a load right after a store to the same word
      // sees the data written at the previous edge.
      rd_word = mem_q[word_idx];
      rd_byte = rd_word[{lane, 3'b000} +: 8];
      rd_half = rd_word[{lane[1], 4'b0000} +: 16];
      case (req_funct3)
         F3_B:    ld_val = {{(XLEN-8){rd_byte[7]}}, rd_byte};
         F3_H:    ld_val = {{(XLEN-16){rd_half[15]}}, rd_half};
         F3_BU:   ld_val = {{(XLEN-8){1'b0}}, rd_byte};
         F3_HU:   ld_val = {{(XLEN-16){1'b0}}, rd_half};
         default: ld_val = rd_word;
      endcase
   end

   // --------------------------------------------------------------------------
   // Response pipeline: stage 0 captures at the acceptance edge, the last stage
   // drives the outputs. Data and error are zero whenever the stage is empty.
   // --------------------------------------------------------------------------
   always_comb begin
      for (int i = 0; i < LAT; i++) begin
         if (i == 0) begin
            pipe_valid_d[i] = accept;
            pipe_err_d[i]   = accept && illegal;
            pipe_data_d[i]  = (accept && !illegal && !req_we) ? ld_val : '0;
         end else begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_err_d[i]   = pipe_err_q[i-1];
            pipe_data_d[i]  = pipe_data_q[i-1];
         end
      end
   end

   assign rsp_valid = pipe_valid_q[LAT-1];
   assign rsp_data  = pipe_data_q[LAT-1];
   assign rsp_err   = pipe_err_q[LAT-1];

   // --------------------------------------------------------------------------
   // Control and pipeline registers.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_INIT;
         clr_cnt_q <= '0;
         for (int i = 0; i < LAT; i++) begin
            pipe_valid_q[i] <= 1'b0;
            pipe_err_q[i]   <= 1'b0;
            pipe_data_q[i]  <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments so every register samples the values
         // from before this edge, independent of statement order.
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         for (int i = 0; i < LAT; i++) begin
            pipe_valid_q[i] <= pipe_valid_d[i];
            pipe_err_q[i]   <= pipe_err_d[i];
            pipe_data_q[i]  <= pipe_data_d[i];
         end
      end
   end

   // --------------------------------------------------------------------------
   // Memory array.
   // NOTE: no reset term; contents are defined by the INIT sweep, which keeps
   // the array mappable onto RAM macros.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (clr_en) begin
         mem_q[clr_cnt_q] <= '0;
      end else if (st_en) begin
         for (int b = 0; b < 4; b++) begin
            if (st_be[b]) mem_q[word_idx][8*b +: 8] <= st_word[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_data_mem_pipe.sv
// -----------------------------------------------------------------------------
// tb_data_mem_pipe
//   Directed bench for data_mem_pipe. Two instances share the same stimulus:
//   dut (LAT=1) for functional checks, dut_l3 (LAT=3) for latency, ordering and
//   reset-with-responses-in-flight. Inputs change on the falling edge and
//   outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_data_mem_pipe;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        ready1, rv1, re1;
   logic [31:0] rd1;
   logic        ready3, rv3, re3;
   logic [31:0] rd3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   data_mem_pipe #(.XLEN(32), .DEPTH(64), .LAT(1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(ready1), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv1), .rsp_data(rd1), .rsp_err(re1)
   );

   data_mem_pipe #(.XLEN(32), .DEPTH(64), .LAT(3)) dut_l3 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(ready3), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv3), .rsp_data(rd3), .rsp_err(re3)
   );

   task automatic set_req(input logic v, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata);
      req_valid  = v;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
   endtask

   // One request on the LAT=1 instance; starts and ends on a falling edge.
   // rsp = {rsp_valid, rsp_err, rsp_data} observed one cycle after acceptance.
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [33:0] rsp);
      set_req(1'b1, we, f3, addr, wdata);
      @(posedge clk);
      @(negedge clk);
      rsp = {rv1, re1, rd1};
      set_req(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
   endtask

   // Waits for req_ready of the selected instance, counting rising edges.
   task automatic wait_ready(input bit use_l3, output int cyc, output int spurious);
      cyc = 0;
      spurious = 0;
      while (cyc < 200) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (rv1 || rv3) spurious++;
         if (use_l3 ? ready3 : ready1) break;
      end
   endtask

   task automatic test_reset;
      logic [33:0] r;
      int cyc, spurious;
      rst = 1'b0;
      set_req(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
      repeat (3) @(negedge clk);
      checks++;
      if ({ready1, rv1, re1, rd1} !== 35'h0) begin
         errors++;
         $display("FAIL reset_outputs_l1: got %h expected 0", {ready1, rv1, re1, rd1});
      end
      checks++;
      if ({ready3, rv3, re3, rd3} !== 35'h0) begin
         errors++;
         $display("FAIL reset_outputs_l3: got %h expected 0", {ready3, rv3, re3, rd3});
      end
      // Release reset while offering a load that INIT must ignore.
      rst = 1'b1;
      set_req(1'b1, 1'b0, F3_W, 32'h0, 32'h0);
      wait_ready(1'b0, cyc, spurious);
      set_req(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
      checks++;
      if (cyc !== 64) begin
         errors++;
         $display("FAIL init_cycles: got %0d expected 64", cyc);
      end
      checks++;
      if (spurious !== 0) begin
         errors++;
         $display("FAIL init_ignores_req: got %0d responses expected 0", spurious);
      end
      checks++;
      if (ready3 !== 1'b1) begin
         errors++;
         $display("FAIL init_ready_l3: got %b expected 1", ready3);
      end
      issue(1'b0, F3_W, 32'h3C, 32'h0, r);
      checks++;
      if (r !== {2'b10, 32'h0}) begin
         errors++;
         $display("FAIL init_lw_3c: got %h expected %h", r, {2'b10, 32'h0});
      end
   endtask

   task automatic test_extend;
      logic [33:0] r;
      logic        we   [7];
      logic [2:0]  f3   [7];
      logic [31:0] addr [7];
      logic [31:0] exp  [7];
      we = '{1, 0, 0, 0, 0, 0, 0};
      f3 = '{F3_W, F3_B, F3_BU, F3_H, F3_HU, F3_B, F3_BU};
      addr = '{32'h10, 32'h10, 32'h10, 32'h12, 32'h12, 32'h11, 32'h11};
      exp = '{32'h0, 32'h7F, 32'h7F, 32'hFFFF_8000, 32'h0000_8000,
              32'hFFFF_FFFF, 32'h0000_00FF};
      for (int i = 0; i < 7; i++) begin
         issue(we[i], f3[i], addr[i], 32'h8000_FF7F, r);
         checks++;
         if (r !== {2'b10, exp[i]}) begin
            errors++;
            $display("FAIL extend_%0d: got %h expected %h", i, r, {2'b10, exp[i]});
         end
      end
   endtask

   task automatic test_partial_store;
      logic [33:0] r;
      issue(1'b1, F3_W, 32'h20, 32'h1122_3344, r);
      issue(1'b1, F3_B, 32'h21, 32'h1234_56AA, r);
      checks++;
      if (r !== {2'b10, 32'h0}) begin
         errors++;
         $display("FAIL sb_rsp: got %h expected %h", r, {2'b10, 32'h0});
      end
      issue(1'b1, F3_H, 32'h22, 32'hDEAD_BEEF, r);
      issue(1'b0, F3_W, 32'h20, 32'h0, r);
      checks++;
      if (r !== {2'b10, 32'hBEEF_AA44}) begin
         errors++;
         $display("FAIL partial_lw_20: got %h expected %h", r, {2'b10, 32'hBEEF_AA44});
      end
   endtask

   task automatic test_illegal;
      logic [33:0] r;
      logic        we   [7];
      logic [2:0]  f3   [7];
      logic [31:0] addr [7];
      issue(1'b1, F3_W, 32'h00, 32'hCAFE_F00D, r);
      we = '{0, 1, 0, 0, 1, 1, 0};
      f3 = '{F3_W, F3_H, F3_W, F3_D, F3_BU, F3_W, F3_HU};
      addr = '{32'h22, 32'h03, 32'h100, 32'h00, 32'h00, 32'h100, 32'h01};
      for (int i = 0; i < 7; i++) begin
         issue(we[i], f3[i], addr[i], 32'h1234_5678, r);
         checks++;
         if (r !== {2'b11, 32'h0}) begin
            errors++;
            $display("FAIL illegal_%0d: got %h expected %h", i, r, {2'b11, 32'h0});
         end
      end
      issue(1'b0, F3_W, 32'h00, 32'h0, r);
      checks++;
      if (r !== {2'b10, 32'hCAFE_F00D}) begin
         errors++;
         $display("FAIL illegal_no_effect: got %h expected %h", r, {2'b10, 32'hCAFE_F00D});
      end
      issue(1'b1, F3_W, 32'hFC, 32'h0BAD_C0DE, r);
      issue(1'b0, F3_W, 32'hFC, 32'h0, r);
      checks++;
      if (r !== {2'b10, 32'h0BAD_C0DE}) begin
         errors++;
         $display("FAIL last_word: got %h expected %h", r, {2'b10, 32'h0BAD_C0DE});
      end
   endtask

   task automatic test_back_to_back;
      logic [33:0] r, e1, e3;
      logic [31:0] w [4];
      w = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};
      for (int i = 0; i < 4; i++) issue(1'b1, F3_W, 32'h40 + 32'(4*i), w[i], r);
      repeat (4) @(negedge clk);
      // Iteration k drives the request for edge k and samples just after it.
      for (int k = 0; k < 9; k++) begin
         if (k < 4) set_req(1'b1, 1'b0, F3_W, 32'h40 + 32'(4*k), 32'h0);
         else       set_req(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
         @(posedge clk);
         @(negedge clk);
         e1 = 34'h0;
         e3 = 34'h0;
         if (k < 4)            e1 = {2'b10, w[k]};
         if (k >= 2 && k <= 5) e3 = {2'b10, w[k-2]};
         checks++;
         if ({rv1, re1, rd1} !== e1) begin
            errors++;
            $display("FAIL b2b_l1_cyc%0d: got %h expected %h", k, {rv1, re1, rd1}, e1);
         end
         checks++;
         if ({rv3, re3, rd3} !== e3) begin
            errors++;
            $display("FAIL b2b_l3_cyc%0d: got %h expected %h", k, {rv3, re3, rd3}, e3);
         end
      end
      // Store immediately followed by a load of the same word.
      for (int k = 0; k < 5; k++) begin
         if (k == 0)      set_req(1'b1, 1'b1, F3_W, 32'h50, 32'h5A5A_1234);
         else if (k == 1) set_req(1'b1, 1'b0, F3_W, 32'h50, 32'h0);
         else             set_req(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
         @(posedge clk);
         @(negedge clk);
         e1 = 34'h0;
         e3 = 34'h0;
         if (k == 0) e1 = {2'b10, 32'h0};
         if (k == 1) e1 = {2'b10, 32'h5A5A_1234};
         if (k == 2) e3 = {2'b10, 32'h0};
         if (k == 3) e3 = {2'b10, 32'h5A5A_1234};
         checks++;
         if ({rv1, re1, rd1} !== e1) begin
            errors++;
            $display("FAIL st_ld_l1_cyc%0d: got %h expected %h", k, {rv1, re1, rd1}, e1);
         end
         checks++;
         if ({rv3, re3, rd3} !== e3) begin
            errors++;
            $display("FAIL st_ld_l3_cyc%0d: got %h expected %h", k, {rv3, re3, rd3}, e3);
         end
      end
   endtask

   task automatic test_reset_inflight;
      logic [33:0] r;
      int cyc, spurious;
      set_req(1'b1, 1'b0, F3_W, 32'h40, 32'h0);
      @(posedge clk);
      @(negedge clk);
      set_req(1'b1, 1'b0, F3_W, 32'h44, 32'h0);
      @(posedge clk);
      @(negedge clk);
      set_req(1'b0, 1'b0, F3_W, 32'h0, 32'h0);
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({rv3, re3, rd3} !== {2'b10, 32'h1111_0001}) begin
         errors++;
         $display("FAIL inflight_first_rsp: got %h expected %h", {rv3, re3, rd3},
                  {2'b10, 32'h1111_0001});
      end
      #1 rst = 1'b0;
      #1;
      checks++;
      if ({ready3, rv3, re3, rd3, ready1, rv1} !== 37'h0) begin
         errors++;
         $display("FAIL reset_async_drop: got %h expected 0",
                  {ready3, rv3, re3, rd3, ready1, rv1});
      end
      @(negedge clk);
      rst = 1'b1;
      wait_ready(1'b1, cyc, spurious);
      checks++;
      if (cyc !== 64) begin
         errors++;
         $display("FAIL reinit_cycles: got %0d expected 64", cyc);
      end
      checks++;
      if (spurious !== 0) begin
         errors++;
         $display("FAIL stale_rsp: got %0d responses expected 0", spurious);
      end
      issue(1'b0, F3_W, 32'h40, 32'h0, r);
      checks++;
      if (r !== {2'b10, 32'h0}) begin
         errors++;
         $display("FAIL reinit_cleared: got %h expected %h", r, {2'b10, 32'h0});
      end
   endtask

   initial begin
      test_reset();
      test_extend();
      test_partial_store();
      test_illegal();
      test_back_to_back();
      test_reset_inflight();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
